rv32_multicycle_sequencer: RTL
==============================

Name: rv32_multicycle_sequencer

Overview:
Multi-cycle RV32I control sequencer. Owns PC and IR and steps each instruction through fetch, decode, execute, memory and writeback. Shares one memory port between instruction fetch and load/store by time-multiplexing it. The ALU and register file stay in the datapath; this block only supplies their enables, the memory handshake and trap reporting.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
MEM_TIMEOUT, 16, cycles a memory request may wait for ack before a bus-error trap; 0 disables the timeout.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset; synchronous and active-high.
mem_req  out  1  memory request; held high until ack.
mem_we  out  1  1 = store, 0 = read.
mem_addr  out  32  PC during fetch, data_addr during load/store.
mem_ack  in  1  request complete this cycle.
mem_rdata  in  32  fetch or load data, valid with mem_ack.
data_addr  in  32  load/store effective address from the ALU.
next_pc_target  in  32  branch/JAL/JALR target from the datapath.
branch_taken  in  1  branch condition true; sampled in WRITEBACK.
pc  out  32  current PC.
ir  out  32  latched instruction.
alu_en  out  1  high in EXECUTE.
rf_we  out  1  register-file write strobe, one cycle.
state  out  3  FSM state code, for debug.
trap  out  1  sticky halt indicator.
trap_cause  out  3  0 none, 1 illegal, 2 misaligned target, 3 ECALL, 4 EBREAK, 5 bus timeout.
instret  out  64  retired-instruction count (see Optional Feature).

Behaviour:
- Reset values: pc=RESET_PC, ir=0, state=FETCH(0), trap=0, trap_cause=0, instret=0. mem_req, mem_we, alu_en and rf_we are 0 in the reset cycle.
- rst high in any state, including mid-handshake, aborts the operation. mem_req drops on the next edge.
- State codes: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4, TRAP=7.
- FETCH: mem_req=1, mem_we=0, mem_addr=pc. On mem_ack: ir<=mem_rdata, go to DECODE. Otherwise stay.
- DECODE (1 cycle), by opcode ir[6:0]:
  - LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, MISC-MEM, SYSTEM go to EXECUTE.
  - Any other opcode, or an invalid funct3/funct7 for OP/OP-IMM/BRANCH/LOAD/STORE: TRAP, cause 1.
  - ECALL: TRAP, cause 3. EBREAK: TRAP, cause 4.
  - FENCE/FENCE.I execute as a NOP.
- EXECUTE (1 cycle): alu_en=1. LOAD or STORE goes to MEM; everything else goes to WRITEBACK.
- MEM: mem_req=1, mem_addr=data_addr, mem_we=1 for STORE. On mem_ack go to WRITEBACK. For a LOAD, the datapath captures mem_rdata on the same cycle.
- WRITEBACK (1 cycle):
  - rf_we=1 if the opcode writes rd (LUI, AUIPC, JAL, JALR, OP, OP-IMM, LOAD, CSR*) and ir[11:7]!=0. Otherwise rf_we=0.
  - PC update: pc<=next_pc_target for JAL, JALR, or BRANCH with branch_taken. Otherwise pc<=pc+4, wrapping modulo 2^32.
  - If the selected target has target[1:0]!=0: TRAP, cause 2, pc unchanged, rf_we=0.
  - Otherwise go to FETCH.
- Latency with ack in the first request cycle: 4 cycles per instruction without a memory access, 5 for LOAD/STORE.
- Timeout: a counter clears on entry to FETCH or MEM and increments each cycle mem_req is high without mem_ack. When MEM_TIMEOUT!=0 and count==MEM_TIMEOUT-1 without ack: TRAP, cause 5.
  - An ack arriving in that same cycle wins; no trap is taken.
- TRAP: all strobes 0, mem_req=0, trap=1, pc and ir frozen. Only rst exits this state.
- trap_cause records the first trap only and is never overwritten.

Optional Feature:
Macro SEQ_INSTRET_EN.
- Defined: instret increments by 1 on every WRITEBACK that goes to FETCH (retired instruction). Trapping instructions are not counted. Wraps at 2^64. Reset to 0.
- Undefined: instret is tied to 64'h0 and no counter logic is built.

Test Plan:
1. Reset; fetch 0x00500093 (ADDI x1,x0,5), ack immediate -> mem_addr=0x0; DECODE, EXECUTE, WRITEBACK follow; rf_we=1 in cycle 4; pc=0x4.
2. LW 0x0000A103, data_addr=0x100, ack delayed 3 cycles -> mem_addr=0x100 held with mem_req=1 and mem_we=0 for 4 cycles; rf_we=1 once; pc+=4.
3. SW 0x0020A223 -> mem_we=1 in MEM; rf_we=0 in WRITEBACK. BEQ with branch_taken=1, target 0x40 -> pc=0x40. With target 0x42 -> trap=1, cause 2, pc unchanged.
4. ir=0x00000000 -> TRAP, cause 1. ir=0x00100073 -> TRAP, cause 4. Both: mem_req stays 0 until rst, and reset returns pc=RESET_PC.
5. MEM_TIMEOUT=16, never ack fetch -> trap=1, cause 5 after 16 request cycles. Repeat with ack on cycle 16 -> no trap. Assert rst mid-request -> mem_req=0 the next cycle.
6. SEQ_INSTRET_EN defined: 10 ADDIs -> instret=10. Add a trapping instruction -> instret stays 10. Undefined: instret=0 throughout.

Source files
------------

// File: rtl/rv32_multicycle_sequencer.sv
// Multi-cycle RV32I control sequencer: owns PC/IR and walks FETCH/DECODE/EXECUTE/MEM/WRITEBACK.
// Optional retired-instruction counter is built when SEQ_INSTRET_EN is defined.
module rv32_multicycle_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic [31:0] data_addr,
    input  logic [31:0] next_pc_target,
    input  logic        branch_taken,
    output logic [31:0] pc,
    output logic [31:0] ir,
    output logic        alu_en,
    output logic        rf_we,
    output logic [2:0]  state,
    output logic        trap,
    output logic [2:0]  trap_cause,
    output logic [63:0] instret
);

    localparam logic [2:0] S_FETCH     = 3'd0;
    localparam logic [2:0] S_DECODE    = 3'd1;
    localparam logic [2:0] S_EXECUTE   = 3'd2;
    localparam logic [2:0] S_MEM       = 3'd3;
    localparam logic [2:0] S_WRITEBACK = 3'd4;
    localparam logic [2:0] S_TRAP      = 3'd7;

    localparam logic [2:0] CAUSE_ILLEGAL    = 3'd1;
    localparam logic [2:0] CAUSE_MISALIGNED = 3'd2;
    localparam logic [2:0] CAUSE_ECALL      = 3'd3;
    localparam logic [2:0] CAUSE_EBREAK     = 3'd4;
    localparam logic [2:0] CAUSE_BUS        = 3'd5;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic        dec_legal;
    logic        dec_writes_rd;
    logic        dec_mem;
    logic        dec_store;
    logic        dec_jump;
    logic        dec_branch;
    logic        dec_ecall;
    logic        dec_ebreak;
    logic        take_target;
    logic [31:0] wb_target;
    logic        wb_misaligned;
    logic [31:0] wait_cnt;
    logic        timed_out;
    logic [2:0]  next_state;
    logic        trap_take;
    logic [2:0]  trap_code;

    assign opcode = ir[6:0];
    assign funct3 = ir[14:12];
    assign funct7 = ir[31:25];
    assign rd     = ir[11:7];

    always_comb begin
        dec_legal     = 1'b1;
        dec_writes_rd = 1'b0;
        dec_mem       = 1'b0;
        dec_store     = 1'b0;
        dec_jump      = 1'b0;
        dec_branch    = 1'b0;
        case (opcode)
            OPC_LUI, OPC_AUIPC: dec_writes_rd = 1'b1;
            OPC_JAL, OPC_JALR: begin
                dec_writes_rd = 1'b1;
                dec_jump      = 1'b1;
            end
            OPC_BRANCH: begin
                dec_branch = 1'b1;
                dec_legal  = (funct3 != 3'b010) && (funct3 != 3'b011);
            end
            OPC_LOAD: begin
                dec_writes_rd = 1'b1;
                dec_mem       = 1'b1;
                dec_legal     = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
            end
            OPC_STORE: begin
                dec_mem   = 1'b1;
                dec_store = 1'b1;
                dec_legal = funct3 inside {3'b000, 3'b001, 3'b010};
            end
            OPC_OP_IMM: begin
                dec_writes_rd = 1'b1;
                // Only the shift-immediates constrain the upper immediate bits.
                if (funct3 == 3'b001) begin
                    dec_legal = (funct7 == 7'b0000000);
                end else if (funct3 == 3'b101) begin
                    dec_legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                end
            end
            OPC_OP: begin
                dec_writes_rd = 1'b1;
                dec_legal = (funct7 == 7'b0000000) ||
                            ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
            end
            OPC_MISC_MEM: begin
                dec_legal = 1'b1;
            end
            OPC_SYSTEM: dec_writes_rd = (funct3 != 3'b000);
            default: dec_legal = 1'b0;
        endcase
    end

    assign dec_ecall  = (ir == 32'h0000_0073);
    assign dec_ebreak = (ir == 32'h0010_0073);

    assign take_target   = dec_jump || (dec_branch && branch_taken);
    assign wb_target     = take_target ? next_pc_target : pc + 32'd4;
    assign wb_misaligned = take_target && (next_pc_target[1:0] != 2'b00);

    // Handshake: in FETCH and MEM, mem_req stays high (with stable mem_addr/mem_we)
    // until a cycle in which mem_ack is high; that cycle completes the transfer.
    assign mem_req  = !rst && ((state == S_FETCH) || (state == S_MEM));
    assign mem_we   = !rst && (state == S_MEM) && dec_store;
    assign mem_addr = (state == S_MEM) ? data_addr : pc;
    assign alu_en   = !rst && (state == S_EXECUTE);
    assign rf_we    = !rst && (state == S_WRITEBACK) && dec_writes_rd &&
                      (rd != 5'd0) && !wb_misaligned;
    assign trap     = (state == S_TRAP);

    // An ack in the final allowed cycle completes normally rather than trapping.
    assign timed_out = (MEM_TIMEOUT != 32'd0) && mem_req && !mem_ack &&
                       (wait_cnt == 32'(MEM_TIMEOUT - 32'd1));

    always_comb begin
        next_state = state;
        trap_take  = 1'b0;
        trap_code  = 3'd0;
        case (state)
            S_FETCH: begin
                if (mem_ack) begin
                    next_state = S_DECODE;
                end else if (timed_out) begin
                    trap_take = 1'b1;
                    trap_code = CAUSE_BUS;
                end
            end
            S_DECODE: begin
                if (!dec_legal) begin
                    trap_take = 1'b1;
                    trap_code = CAUSE_ILLEGAL;
                end else if (dec_ecall) begin
                    trap_take = 1'b1;
                    trap_code = CAUSE_ECALL;
                end else if (dec_ebreak) begin
                    trap_take = 1'b1;
                    trap_code = CAUSE_EBREAK;
                end else begin
                    next_state = S_EXECUTE;
                end
            end
            S_EXECUTE: next_state = dec_mem ? S_MEM : S_WRITEBACK;
            S_MEM: begin
                if (mem_ack) begin
                    next_state = S_WRITEBACK;
                end else if (timed_out) begin
                    trap_take = 1'b1;
                    trap_code = CAUSE_BUS;
                end
            end
            S_WRITEBACK: begin
                if (wb_misaligned) begin
                    trap_take = 1'b1;
                    trap_code = CAUSE_MISALIGNED;
                end else begin
                    next_state = S_FETCH;
                end
            end
            S_TRAP: next_state = S_TRAP;
            default: begin
                trap_take = 1'b1;
                trap_code = CAUSE_ILLEGAL;
            end
        endcase
        if (trap_take) begin
            next_state = S_TRAP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_FETCH;
            pc         <= RESET_PC;
            ir         <= 32'h0;
            trap_cause <= 3'd0;
            wait_cnt   <= 32'd0;
        end else begin
            state <= next_state;
            if (trap_take && (trap_cause == 3'd0)) begin
                trap_cause <= trap_code;
            end
            if ((state == S_FETCH) && mem_ack) begin
                ir <= mem_rdata;
            end
            if ((state == S_WRITEBACK) && !wb_misaligned) begin
                pc <= wb_target;
            end
            if ((next_state != state) && ((next_state == S_FETCH) || (next_state == S_MEM))) begin
                wait_cnt <= 32'd0;
            end else if (mem_req && !mem_ack) begin
                wait_cnt <= wait_cnt + 32'd1;
            end
        end
    end

`ifdef SEQ_INSTRET_EN
    logic [63:0] instret_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            instret_cnt <= 64'h0;
        end else if ((state == S_WRITEBACK) && !wb_misaligned) begin
            instret_cnt <= instret_cnt + 64'd1;
        end
    end

    assign instret = instret_cnt;
`else
    assign instret = 64'h0;
`endif

endmodule
